// File: rtl/kernel_sysinfo_pkg.sv
// Shared constants for the system-information block: register map, CONTROL bit
// positions and counter width.
package kernel_sysinfo_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int UPTIME_W = 64;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_SYSTEM_ID = 3'd0,
        ADDR_BUILD_TS  = 3'd1,
        ADDR_UPTIME_LO = 3'd2,
        ADDR_UPTIME_HI = 3'd3,
        ADDR_CONTROL   = 3'd4,
        ADDR_SCRATCH0  = 3'd5
    } addr_e;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // Word address of scratch register idx.
    function automatic logic [ADDR_W-1:0] scratch_addr(input int idx);
        return ADDR_W'(int'(ADDR_SCRATCH0) + idx);
    endfunction

endpackage

// File: rtl/kernel_sysinfo_rdpipe.sv
// Read-return delay line: DEPTH registered stages of valid plus data, data forced
// to zero on any stage that does not hold a valid read.
module kernel_sysinfo_rdpipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH:0]     w_vchain;
    logic [WIDTH-1:0]   w_dchain [DEPTH+1];
    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data [DEPTH];

    assign w_vchain[0] = i_valid;
    assign w_dchain[0] = i_data;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign w_vchain[gi+1] = r_valid[gi];
            assign w_dchain[gi+1] = r_data[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= w_vchain[i];
                r_data[i]  <= w_vchain[i] ? w_dchain[i] : '0;
            end
        end
    end

    assign o_valid = w_vchain[DEPTH];
    assign o_data  = w_dchain[DEPTH];

endmodule

// File: rtl/kernel_sysinfo.sv
// Avalon-MM system-information slave: ID/timestamp constants, 64-bit uptime counter
// with tear-free high-word shadow, CONTROL register and scratch words.
module kernel_sysinfo
    import kernel_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID       = 32'd1483580087,
    parameter logic [31:0] BUILD_TIMESTAMP = 32'd0,
    parameter int          NUM_SCRATCH     = 2,
    parameter int          READ_LATENCY    = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    logic                   r_ctrl_en;
    logic [UPTIME_W-1:0]    r_uptime;
    logic [DATA_W-1:0]      r_shadow;
    logic [DATA_W-1:0]      r_scratch [NUM_SCRATCH];

    logic                   w_rd_accept;
    logic                   w_ctrl_wr;
    logic                   w_clear;
    logic [NUM_SCRATCH-1:0] w_scr_wr;
    logic [DATA_W-1:0]      w_rdata;
    logic [DATA_W-1:0]      w_pipe_data;

    // A write in the same cycle wins; the read is simply not accepted.
    assign w_rd_accept = read & ~write;
    assign w_ctrl_wr   = write && (address == ADDR_CONTROL);
    assign w_clear     = w_ctrl_wr && writedata[CTRL_CLR_BIT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scr_sel
            assign w_scr_wr[gi] = write && (address == scratch_addr(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_en <= 1'b1;
            r_uptime  <= '0;
            r_shadow  <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl_en <= writedata[CTRL_EN_BIT];
            end
            if (w_clear) begin
                r_uptime <= '0;
            end else if (r_ctrl_en) begin
                r_uptime <= r_uptime + UPTIME_W'(1);
            end
            if (w_rd_accept && (address == ADDR_UPTIME_LO)) begin
                r_shadow <= r_uptime[UPTIME_W-1:DATA_W];
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_scr_wr[i]) begin
                    r_scratch[i] <= writedata;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_SYSTEM_ID: w_rdata = SYSTEM_ID;
            ADDR_BUILD_TS:  w_rdata = BUILD_TIMESTAMP;
            ADDR_UPTIME_LO: w_rdata = r_uptime[DATA_W-1:0];
            ADDR_UPTIME_HI: w_rdata = r_shadow;
            ADDR_CONTROL:   w_rdata[CTRL_EN_BIT] = r_ctrl_en;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == scratch_addr(i)) begin
                        w_rdata = r_scratch[i];
                    end
                end
            end
        endcase
    end

    assign w_pipe_data = w_rd_accept ? w_rdata : '0;

    kernel_sysinfo_rdpipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (DATA_W)
    ) u_rdpipe (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (w_rd_accept),
        .i_data  (w_pipe_data),
        .o_valid (readdatavalid),
        .o_data  (readdata)
    );

endmodule

// File: tb/tb_kernel_sysinfo.sv
// Scoreboard bench: two instances (read latency 1 and 3) share one stimulus bus;
// a register-map model predicts each read and a monitor checks data and timing.
module tb_kernel_sysinfo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] rdata [2];
    logic        rvalid [2];

    kernel_sysinfo dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(rdata[0]), .readdatavalid(rvalid[0])
    );

    kernel_sysinfo #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(rdata[1]), .readdatavalid(rvalid[1])
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          acc;
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q [2][$];
    int   lat [2] = '{1, 3};
    int   total = 0;
    int   bad = 0;

    // Reference model: counter value at interval n is base + (n - t0) while enabled.
    bit [63:0] m_base;
    int        m_t0;
    bit        m_en;
    bit [31:0] m_shadow;
    bit [31:0] m_scr [2];

    function automatic bit [63:0] m_up(input int n);
        return m_base + (m_en ? 64'(n - m_t0) : 64'd0);
    endfunction

    task automatic model_reset_release(input int n);
        m_base = '0; m_t0 = n; m_en = 1'b1; m_shadow = '0;
        m_scr[0] = '0; m_scr[1] = '0;
    endtask

    task automatic model_write(input int n, input bit [2:0] a, input bit [31:0] d);
        bit [63:0] u;
        if (a == 3'd4) begin
            u = m_up(n);
            m_base = d[1] ? 64'd0 : u + (m_en ? 64'd1 : 64'd0);
            m_t0 = n + 1;
            m_en = d[0];
        end else if (a == 3'd5 || a == 3'd6) begin
            m_scr[a - 3'd5] = d;
        end
    endtask

    task automatic model_read(input int n, input bit [2:0] a);
        bit [63:0] u;
        bit [31:0] v;
        case (a)
            3'd0: v = 32'd1483580087;
            3'd1: v = 32'd0;
            3'd2: begin u = m_up(n); v = u[31:0]; m_shadow = u[63:32]; end
            3'd3: v = m_shadow;
            3'd4: v = {31'd0, m_en};
            3'd5: v = m_scr[0];
            3'd6: v = m_scr[1];
            default: v = 32'd0;
        endcase
        for (int k = 0; k < 2; k++) q[k].push_back('{acc: n, addr: a, data: v});
    endtask

    task automatic bus(input bit rd, input bit wr, input bit [2:0] a, input bit [31:0] d);
        int n;
        @(posedge clock);
        #1;
        read = rd; write = wr; address = a; writedata = d;
        n = cyc;
        if (wr) model_write(n, a, d);
        else if (rd) model_read(n, a);
    endtask

    task automatic idle(input int k);
        repeat (k) bus(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0; read = 1'b0; write = 1'b0;
        for (int k = 0; k < 2; k++) q[k].delete();
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        model_reset_release(cyc);
    endtask

    task automatic preload_counter();
        force dut1.r_uptime = 64'h0000_0000_FFFF_FFFF;
        force dut3.r_uptime = 64'h0000_0000_FFFF_FFFF;
        @(negedge clock);
        release dut1.r_uptime;
        release dut3.r_uptime;
        m_base = 64'h0000_0000_FFFF_FFFF;
        m_t0 = cyc;
    endtask

    // Monitor: every cycle, each instance either presents an expected read at the
    // right time or holds readdata at zero.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (rvalid[k]) begin
                if (q[k].size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid dut%0d cyc=%0d data=%h required=no valid", k, cyc, rdata[k]);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    total++;
                    if (cyc != e.acc + lat[k]) begin
                        bad++;
                        $display("FAIL latency dut%0d addr=%0d got_cycle=%0d required_cycle=%0d", k, e.addr, cyc, e.acc + lat[k]);
                    end
                    total++;
                    if (rdata[k] !== e.data) begin
                        bad++;
                        $display("FAIL readdata dut%0d addr=%0d got=%h required=%h", k, e.addr, rdata[k], e.data);
                    end
                    $display("rd dut%0d acc=%0d addr=%0d data=%h", k, e.acc, e.addr, rdata[k]);
                end
            end else begin
                total++;
                if (rdata[k] !== 32'd0) begin
                    bad++;
                    $display("FAIL idle_data dut%0d cyc=%0d got=%h required=00000000", k, cyc, rdata[k]);
                end
                if (q[k].size() > 0 && q[k][0].acc + lat[k] < cyc) begin
                    total++; bad++;
                    $display("FAIL missing_valid dut%0d addr=%0d cyc=%0d required_cycle=%0d", k, q[k][0].addr, cyc, q[k][0].acc + lat[k]);
                    void'(q[k].pop_front());
                end
            end
        end
    end

    initial begin
        bit        rd, wr;
        bit [2:0]  a;
        bit [31:0] d;

        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        model_reset_release(cyc);

        // Constant words with default parameters.
        bus(1, 0, 3'd0, 0);
        bus(1, 0, 3'd1, 0);
        idle(4);

        // Back-to-back reads through both latencies.
        bus(0, 1, 3'd5, $urandom);
        bus(1, 0, 3'd0, 0);
        bus(1, 0, 3'd5, 0);
        bus(1, 0, 3'd7, 0);
        idle(5);

        // Simultaneous read and write: write wins, read dropped.
        bus(1, 1, 3'd5, 32'hA5A5_A5A5);
        bus(1, 0, 3'd5, 0);
        idle(4);

        // Clear with counting stopped, then clear and restart.
        bus(0, 1, 3'd4, 32'h2);
        idle(10);
        bus(1, 0, 3'd2, 0);
        bus(1, 0, 3'd3, 0);
        bus(0, 1, 3'd4, 32'h3);
        bus(1, 0, 3'd2, 0);
        idle(3);
        bus(1, 0, 3'd2, 0);
        bus(1, 0, 3'd4, 0);
        idle(4);

        // Low-word rollover with tear-free high shadow.
        bus(0, 1, 3'd4, 32'h0);
        idle(1);
        preload_counter();
        bus(1, 0, 3'd2, 0);
        bus(1, 0, 3'd3, 0);
        bus(0, 1, 3'd4, 32'h1);
        idle(2);
        bus(1, 0, 3'd2, 0);
        bus(1, 0, 3'd3, 0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd4) d[1:0] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
            bus(rd, wr, a, d);
        end
        idle(4);

        // Reset with reads in flight.
        bus(0, 1, 3'd6, 32'hDEAD_BEEF);
        bus(1, 0, 3'd0, 0);
        bus(1, 0, 3'd5, 0);
        pulse_reset();
        idle(2);
        bus(1, 0, 3'd5, 0);
        bus(1, 0, 3'd6, 0);
        bus(1, 0, 3'd4, 0);
        bus(1, 0, 3'd2, 0);
        bus(1, 0, 3'd3, 0);
        idle(6);

        for (int k = 0; k < 2; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL drain dut%0d pending=%0d required=0", k, q[k].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
